// File: rtl/dds_pkg.sv
// Shared definitions for the multi-voice DDS engine: wave codes, control-byte
// bit positions and the offset-binary midscale helper.
package dds_pkg;

    typedef enum logic [2:0] {
        WAVE_SAW  = 3'd0,
        WAVE_RAMP = 3'd1,
        WAVE_SQR  = 3'd2,
        WAVE_TRI  = 3'd3,
        WAVE_SINE = 3'd4
    } wave_e;

    localparam int CTL_MUTE = 3;
    localparam int CTL_PRST = 4;
    localparam int CTL_W    = 5;

    function automatic int unsigned midscale(input int unsigned out_w);
        return 32'd1 << (out_w - 32'd1);
    endfunction

endpackage

// File: rtl/dds_voice_bank_if.sv
// Shadow-register write bus and commit handshake of dds_voice_bank.
interface dds_voice_bank_if #(
    parameter int VOICES = 2,
    parameter int TUNE_W = 16
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW = $clog2(TUNE_W / 8 + 1);

    logic          wr_en;
    logic [VW-1:0] wr_voice;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          commit;
    logic          commit_pending;

    modport master (output wr_en, wr_voice, wr_addr, wr_data, commit, input commit_pending);
    modport slave  (input wr_en, wr_voice, wr_addr, wr_data, commit, output commit_pending);
endinterface

// File: rtl/dds_sine_quarter.sv
// Quarter-wave sine lookup, offset-binary output; built only with DDS_SINE_EN.
// Table contents come from a rational sine approximation evaluated at elaboration.
module dds_sine_quarter
    import dds_pkg::*;
#(
    parameter int OUT_W   = 12,
    parameter int SINE_AW = 6
) (
    input  logic [SINE_AW+1:0] sel,
    output logic [OUT_W-1:0]   sample
);
    localparam int N = 2 ** SINE_AW;
    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

    function automatic logic [OUT_W-2:0] amp_f(input longint k);
        longint n, a, num, den;
        n   = longint'(N);
        a   = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
        num = 64'sd4 * k * (64'sd2 * n - k);
        den = 64'sd5 * n * n - k * (64'sd2 * n - k);
        return (OUT_W-1)'((a * num) / den);
    endfunction

    logic [OUT_W-2:0]   rom [N];
    logic [SINE_AW-1:0] idx_s;
    logic [OUT_W-2:0]   amp_s;

    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = amp_f(longint'(i));
    end

    // Mirror the index in odd quadrants, negate about midscale in the lower half
    always_comb begin
        idx_s  = sel[SINE_AW-1:0];
        amp_s  = {(OUT_W-1){1'b0}};
        sample = MID;
        if (sel[SINE_AW]) begin
            idx_s = ~sel[SINE_AW-1:0];
        end else begin
            idx_s = sel[SINE_AW-1:0];
        end
        amp_s = rom[idx_s];
        if (sel[SINE_AW+1]) begin
            sample = MID - {1'b0, amp_s};
        end else begin
            sample = MID + {1'b0, amp_s};
        end
    end

endmodule

// File: rtl/dds_voice.sv
// One DDS voice: shadow/active tuning and control, phase accumulator, waveform register.
// Wave 4 is a sine when DDS_SINE_EN is defined, otherwise a triangle.
module dds_voice
    import dds_pkg::*;
#(
    parameter int TUNE_W  = 16,
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12,
    parameter int SINE_AW = 6,
    parameter int AW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             apply,
    input  logic             load,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    output logic [OUT_W-1:0] sample
);
    localparam int NB = TUNE_W / 8;
    localparam logic [OUT_W-1:0] MID     = OUT_W'(midscale(OUT_W));
    localparam logic [CTL_W-1:0] CTL_RST = 5'b01000;

    logic [TUNE_W-1:0] tune_sh_r, tune_act_r, acc_r, tune_nxt_s;
    logic [CTL_W-1:0]  ctl_sh_r, ctl_act_r;
    logic [OUT_W-1:0]  wave_s, tri_s, sine_s;

    assign tune_nxt_s = apply ? tune_sh_r : tune_act_r;
    assign tri_s = acc_r[TUNE_W-1] ? ~acc_r[TUNE_W-2 -: OUT_W] : acc_r[TUNE_W-2 -: OUT_W];

`ifdef DDS_SINE_EN
    dds_sine_quarter #(.OUT_W(OUT_W), .SINE_AW(SINE_AW)) u_sine (
        .sel    (acc_r[TUNE_W-1 -: SINE_AW+2]),
        .sample (sine_s)
    );
`else
    assign sine_s = tri_s;
`endif

    // Shadow byte loads, atomic shadow->active copy and accumulator advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tune_sh_r  <= {TUNE_W{1'b0}};
            tune_act_r <= {TUNE_W{1'b0}};
            acc_r      <= {TUNE_W{1'b0}};
            ctl_sh_r   <= CTL_RST;
            ctl_act_r  <= CTL_RST;
        end else begin
            if (wr_sel) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_addr == AW'(b)) tune_sh_r[8*b +: 8] <= wr_data;
                end
                if (wr_addr == AW'(NB)) ctl_sh_r <= wr_data[CTL_W-1:0];
            end
            if (apply) begin
                tune_act_r <= tune_sh_r;
                ctl_act_r  <= ctl_sh_r;
            end
            if (tick) begin
                acc_r <= (apply && ctl_sh_r[CTL_PRST]) ? {TUNE_W{1'b0}} : acc_r + tune_nxt_s;
            end
        end
    end

    // Waveform select from the phase MSBs
    always_comb begin
        wave_s = MID;
        if (ctl_act_r[CTL_MUTE]) begin
            wave_s = MID;
        end else begin
            case (ctl_act_r[2:0])
                WAVE_SAW:  wave_s = acc_r[TUNE_W-1 -: OUT_W];
                WAVE_RAMP: wave_s = ~acc_r[TUNE_W-1 -: OUT_W];
                WAVE_SQR:  wave_s = acc_r[TUNE_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
                WAVE_TRI:  wave_s = tri_s;
                WAVE_SINE: wave_s = sine_s;
                default:   wave_s = MID;
            endcase
        end
    end

    // Per-voice sample register, one cycle after the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= {OUT_W{1'b0}};
        end else if (load) begin
            sample <= wave_s;
        end
    end

endmodule

// File: rtl/dds_voice_bank.sv
// Multi-voice DDS: prescaled sample tick, commit tracking, write decode and averaging mixer.
// Optional sine waveform enabled by defining DDS_SINE_EN.
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter int VOICES  = 2,
    parameter int TUNE_W  = 16,
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12,
    parameter int DIV_W   = 8,
    parameter int SINE_AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [DIV_W-1:0] div,
    dds_voice_bank_if.slave  bus,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid
);
    localparam int LV    = $clog2(VOICES);
    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW    = $clog2(TUNE_W / 8 + 1);
    localparam int NB    = TUNE_W / 8;
    localparam int SUM_W = OUT_W + LV;

    logic [DIV_W-1:0]  cnt_r;
    logic              pend_r, s1_r, s2_r;
    logic              tick_s, apply_s, load_s;
    logic [VOICES-1:0] wr_sel_s;
    logic [OUT_W-1:0]  vsample_s [VOICES];
    logic [SUM_W-1:0]  sum_s;

    // ">=" rather than "==" so lowering div below the running count recovers at once
    assign tick_s  = ena && (cnt_r >= div);
    assign apply_s = tick_s && (pend_r || bus.commit);
    assign load_s  = ena && s1_r;
    assign bus.commit_pending = pend_r;

    // Write decode: out-of-range voice or byte address selects nothing
    always_comb begin
        wr_sel_s = {VOICES{1'b0}};
        for (int v = 0; v < VOICES; v++) begin
            if (bus.wr_en && (bus.wr_addr <= AW'(NB)) && (bus.wr_voice == VW'(v))) begin
                wr_sel_s[v] = 1'b1;
            end else begin
                wr_sel_s[v] = 1'b0;
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        dds_voice #(
            .TUNE_W(TUNE_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .SINE_AW(SINE_AW), .AW(AW)
        ) u_voice (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_s),
            .apply   (apply_s),
            .load    (load_s),
            .wr_sel  (wr_sel_s[v]),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .sample  (vsample_s[v])
        );
    end

    // Mixer sum; width leaves headroom so it cannot overflow
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int v = 0; v < VOICES; v++) begin
            sum_s = sum_s + SUM_W'(vsample_s[v]);
        end
    end

    // Prescaler, commit pending flag, valid pipeline and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= {DIV_W{1'b0}};
            pend_r       <= 1'b0;
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= {OUT_W{1'b0}};
        end else begin
            if (ena) begin
                cnt_r <= tick_s ? {DIV_W{1'b0}} : cnt_r + DIV_W'(1);
                s1_r  <= tick_s;
                s2_r  <= s1_r;
            end
            if (apply_s) begin
                pend_r <= 1'b0;
            end else if (bus.commit) begin
                pend_r <= 1'b1;
            end
            sample_valid <= ena && s2_r;
            if (ena && s2_r) begin
                sample_out <= OUT_W'(sum_s >> LV);
            end
        end
    end

endmodule

// File: tb/tb_dds_voice_bank.sv
// Directed, table-driven bench for dds_voice_bank (VOICES=2, TUNE_W=16, PHASE_W=14, OUT_W=12).
module tb_dds_voice_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [7:0]  div = 8'd0;
    logic [11:0] sample_out;
    logic        sample_valid;

    dds_voice_bank_if #(.VOICES(2), .TUNE_W(16)) bus ();

    dds_voice_bank #(
        .VOICES(2), .TUNE_W(16), .PHASE_W(14), .OUT_W(12), .DIV_W(8), .SINE_AW(6)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .div          (div),
        .bus          (bus),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t0;
        logic [7:0]  c0;
        logic [15:0] t1;
        logic [7:0]  c1;
        logic [11:0] e0, e1, e2;
        string       name;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input int v, input int a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_voice = v[0];
        bus.wr_addr  = a[1:0];
        bus.wr_data  = d;
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    task automatic prog(input int v, input logic [15:0] t, input logic [7:0] c);
        wr(v, 0, t[7:0]);
        wr(v, 1, t[15:8]);
        wr(v, 2, c);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n, last, bad;
        logic [11:0] held;
        logic [15:0] acc_held;

        //            t0        c0     t1        c1     e0       e1       e2
        vecs[0] = '{16'h1000, 8'h10, 16'h0000, 8'h18, 12'h400, 12'h480, 12'h500, "saw_v0"};
        vecs[1] = '{16'h1000, 8'h11, 16'h2000, 8'h10, 12'h7FF, 12'h87F, 12'h8FF, "ramp_saw"};
        vecs[2] = '{16'h6000, 8'h13, 16'h0000, 8'h18, 12'h400, 12'hA00, 12'h7FF, "tri_v0"};
        vecs[3] = '{16'h8000, 8'h12, 16'h8000, 8'h12, 12'h000, 12'hFFF, 12'h000, "square_both"};
        vecs[4] = '{16'h1234, 8'h16, 16'h1234, 8'h15, 12'h800, 12'h800, 12'h800, "wave6_wave5"};
`ifdef DDS_SINE_EN
        vecs[5] = '{16'h0000, 8'h14, 16'h0000, 8'h18, 12'h800, 12'h800, 12'h800, "wave4_phase0"};
`else
        vecs[5] = '{16'h0000, 8'h14, 16'h0000, 8'h18, 12'h400, 12'h400, 12'h400, "wave4_phase0"};
`endif
        vecs[6] = '{16'h4000, 8'h18, 16'h4000, 8'h10, 12'h400, 12'h600, 12'h800, "mute_v0_saw_v1"};

        bus.wr_en = 1'b0; bus.wr_voice = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'd0; bus.commit = 1'b0;
        rst = 1'b1; ena = 1'b1; div = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_sample_out", 32'(sample_out), 32'h000);
        check("reset_sample_valid", 32'(sample_valid), 32'd0);
        check("reset_commit_pending", 32'(bus.commit_pending), 32'd0);
        rst = 1'b0;
        wait_valid(ok);
        check("first_valid_seen", 32'(ok), 32'd1);
        check("first_sample_muted", 32'(sample_out), 32'h800);

        // Voice 0 saw at tune 0x0100, voice 1 muted
        prog(0, 16'h0100, 8'h00);
        bus.commit = 1'b1;
        @(posedge clk); #1;
        check("t2_acc0_apply", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h0100);
        @(negedge clk); bus.commit = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("t2_first_sample", 32'(sample_out), 32'h408);
        check("t2_first_valid", 32'(sample_valid), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("t2_step%0d", k), 32'(sample_out), 32'h408 + 32'(8 * k));
        end

        // Prescaler div=3 and run-enable hold
        @(negedge clk); div = 8'd3;
        repeat (8) @(negedge clk);
        n = 0; last = -1; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sample_valid) begin
                if (last >= 0 && (i - last) != 4) bad++;
                last = i;
                n++;
            end
        end
        check("div3_pulse_count", 32'(n), 32'd10);
        check("div3_gap_errors", 32'(bad), 32'd0);
        @(negedge clk);
        ena = 1'b0;
        held = sample_out;
        acc_held = u_dut.g_voice[0].u_voice.acc_r;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sample_valid) n++;
        end
        check("ena0_no_pulses", 32'(n), 32'd0);
        check("ena0_sample_hold", 32'(sample_out), 32'(held));
        check("ena0_acc_hold", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'(acc_held));
        @(negedge clk); ena = 1'b1; div = 8'd0;

        // Waveform vectors, each committed with phase reset on voice 0
        for (int v = 0; v < 7; v++) begin
            prog(0, vecs[v].t0, vecs[v].c0);
            prog(1, vecs[v].t1, vecs[v].c1);
            bus.commit = 1'b1;
            @(posedge clk); #1;
            check({vecs[v].name, "_acc0"}, 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h0);
            @(negedge clk); bus.commit = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            check({vecs[v].name, "_s0"}, 32'(sample_out), 32'(vecs[v].e0));
            @(posedge clk); #1;
            check({vecs[v].name, "_s1"}, 32'(sample_out), 32'(vecs[v].e1));
            @(posedge clk); #1;
            check({vecs[v].name, "_s2"}, 32'(sample_out), 32'(vecs[v].e2));
        end

        // Shadow write coinciding with commit and tick
        prog(0, 16'h2000, 8'h10);
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b1; bus.wr_en = 1'b1; bus.wr_voice = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h55;
        @(posedge clk); #1;
        check("t5_active_old", 32'(u_dut.g_voice[0].u_voice.tune_act_r), 32'h2000);
        check("t5_shadow_new", 32'(u_dut.g_voice[0].u_voice.tune_sh_r), 32'h2055);
        check("t5_pending_clear", 32'(bus.commit_pending), 32'd0);
        check("t5_acc_prst", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h0);
        @(negedge clk); bus.commit = 1'b0; bus.wr_en = 1'b0;
        @(posedge clk); #1;
        check("t5_acc_old_tune", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h2000);
        @(negedge clk); bus.commit = 1'b1;
        @(posedge clk); #1;
        check("t5_active_second", 32'(u_dut.g_voice[0].u_voice.tune_act_r), 32'h2055);
        @(negedge clk); bus.commit = 1'b0;
        @(posedge clk); #1;
        check("t5_acc_new_tune", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h2055);

        wr(0, 3, 8'hFF);
        check("drop_addr3_tune", 32'(u_dut.g_voice[0].u_voice.tune_sh_r), 32'h2055);
        check("drop_addr3_ctl", 32'(u_dut.g_voice[0].u_voice.ctl_sh_r), 32'h10);

        // Commit between ticks stays pending until the next tick
        @(negedge clk); div = 8'd3;
        prog(0, 16'h0300, 8'h00);
        repeat (4) @(negedge clk);
        wait_valid(ok);
        check("pend_sync_valid", 32'(ok), 32'd1);
        @(negedge clk); bus.commit = 1'b1;
        @(posedge clk); #1;
        check("pend_set", 32'(bus.commit_pending), 32'd1);
        check("pend_active_unchanged", 32'(u_dut.g_voice[0].u_voice.tune_act_r), 32'h2055);
        @(negedge clk); bus.commit = 1'b0;
        @(posedge clk); #1;
        check("pend_cleared_on_tick", 32'(bus.commit_pending), 32'd0);
        check("pend_applied", 32'(u_dut.g_voice[0].u_voice.tune_act_r), 32'h0300);

        // Mid-run reset with a commit outstanding
        wait_valid(ok);
        @(negedge clk); bus.commit = 1'b1;
        @(posedge clk); #1;
        check("midrst_pend_before", 32'(bus.commit_pending), 32'd1);
        @(negedge clk); bus.commit = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_sample_out", 32'(sample_out), 32'h000);
        check("midrst_sample_valid", 32'(sample_valid), 32'd0);
        check("midrst_pending", 32'(bus.commit_pending), 32'd0);
        check("midrst_acc0", 32'(u_dut.g_voice[0].u_voice.acc_r), 32'h0);
        @(negedge clk); rst = 1'b0; div = 8'd0;
        wait_valid(ok);
        check("midrst_valid_seen", 32'(ok), 32'd1);
        check("midrst_first_sample", 32'(sample_out), 32'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
